wddl_nor_pipe: RTL

- Parametrised dual-rail (WDDL) NOR stage for the side-channel-hardened AES datapath.
- Accepts N_IN dual-rail WIDTH-bit operands over a valid/ready handshake and computes their bitwise NOR in positive-only WDDL form.
- Registers the result for one transfer, then forces a precharge (all-zero on both rails) of programmable length before accepting the next operand set.
- Successor to the single-rail 2-input NOR cell: wider, N-ary, dual-rail, sequenced, and encoding-checked.

---
 rtl/wddl_pkg.sv | 10 +
 rtl/wddl_nor_bit.sv | 23 ++
 rtl/wddl_nor_pipe.sv | 88 ++++++++
 3 files changed

// File: rtl/wddl_pkg.sv
// wddl_pkg: shared state encoding, rail constants and pair check for the WDDL NOR stage
package wddl_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, PRE} state_t;
  localparam logic [1:0] WDDL_NULL = 2'b00;
  localparam logic [1:0] WDDL_ONE  = 2'b10;
  localparam logic [1:0] WDDL_ZERO = 2'b01;
  function automatic logic dual_valid(input logic t, input logic f);
    return t ^ f;
  endfunction
endpackage

// File: rtl/wddl_nor_bit.sv
// wddl_nor_bit: one bit position of an N-ary dual-rail NOR with bad-pair detection
//   i_t/i_f : true/false rails of this bit from each operand
//   o_t/o_f : result rails, forced to null when any operand pair is 00 or 11
//   o_bad   : an operand pair at this position is not a valid dual-rail code
module wddl_nor_bit
  import wddl_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0] i_t,
  input  logic [N_IN-1:0] i_f,
  output logic            o_t,
  output logic            o_f,
  output logic            o_bad
);
  logic [N_IN-1:0] w_ok;
  for (genvar i = 0; i < N_IN; i++) begin : g_chk
    assign w_ok[i] = dual_valid(i_t[i], i_f[i]);
  end
  assign o_bad = ~&w_ok;
  // NOR is true only when every operand is false; positive-only, so no inverters on the rails
  assign {o_t, o_f} = o_bad ? WDDL_NULL : {&i_f, |i_t};
endmodule

// File: rtl/wddl_nor_pipe.sv
// wddl_nor_pipe: sequenced N-ary dual-rail NOR stage with forced precharge after every result
//   in_valid/in_ready/in_t/in_f : operand handshake, operand i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready/y_t/y_f : registered result handshake
//   enc_err : accepted operands held a 00/11 pair (held for the whole result period)
//   busy    : stage not idle
//   err_cnt : saturating count of released results with enc_err (only with WDDL_NOR_ERR_CNT_EN)
module wddl_nor_pipe
  import wddl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int N_IN       = 2,
  parameter int PRE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*WIDTH-1:0] in_t,
  input  logic [N_IN*WIDTH-1:0] in_f,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      y_t,
  output logic [WIDTH-1:0]      y_f,
  output logic                  enc_err,
`ifdef WDDL_NOR_ERR_CNT_EN
  output logic [7:0]            err_cnt,
`endif
  output logic                  busy
);
  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] w_yt;
  logic [WIDTH-1:0] w_yf;
  logic [WIDTH-1:0] w_bad;
  logic             w_accept;
  logic             w_release;
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [N_IN-1:0] w_t;
    logic [N_IN-1:0] w_f;
    for (genvar i = 0; i < N_IN; i++) begin : g_op
      assign w_t[i] = in_t[i*WIDTH+b];
      assign w_f[i] = in_f[i*WIDTH+b];
    end
    wddl_nor_bit #(.N_IN(N_IN)) u_bit (
      .i_t  (w_t),
      .i_f  (w_f),
      .o_t  (w_yt[b]),
      .o_f  (w_yf[b]),
      .o_bad(w_bad[b])
    );
  end
  assign in_ready  = r_state == IDLE;
  assign busy      = r_state != IDLE;
  assign w_accept  = in_ready && in_valid;
  assign w_release = r_state == HOLD && out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      y_t       <= '0;
      y_f       <= '0;
      enc_err   <= 1'b0;
      out_valid <= 1'b0;
    end else if (w_accept) begin
      r_state   <= HOLD;
      y_t       <= w_yt;
      y_f       <= w_yf;
      enc_err   <= |w_bad;
      out_valid <= 1'b1;
    end else if (w_release) begin
      r_state   <= PRE;
      r_cnt     <= 4'(PRE_CYCLES - 1);
      y_t       <= '0;
      y_f       <= '0;
      enc_err   <= 1'b0;
      out_valid <= 1'b0;
    end else if (r_state == PRE) begin
      if (r_cnt == '0) r_state <= IDLE;
      else r_cnt <= r_cnt - 4'd1;
    end
  end
`ifdef WDDL_NOR_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt <= '0;
    else if (w_release && enc_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif
endmodule
